// File: rtl/ntt_pkg.sv
// Shared types, widths and the reorder-FIFO depth function for the NTT/INTT sequencer.
package ntt_pkg;

  localparam int N_DEF              = 256;
  localparam int LOG_N              = $clog2(N_DEF);
  localparam int NTT_STAGE_CNT      = LOG_N;
  localparam int MUL_STAGE_CNT      = 6;
  localparam int DATA_WIDTH         = 16;
  localparam int MAX_FIFO_ADDR_BITS = $clog2(N_DEF / 2);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  // Stage index i is in pipeline order; NTT walks the butterfly spans from largest to smallest.
  function automatic int fifo2_depth(input int stage, input logic mode,
                                     input int stages = NTT_STAGE_CNT,
                                     input int mul_lat = MUL_STAGE_CNT);
    int s;
    int hrs;
    s   = mode ? stage : stages - 1 - stage;
    hrs = 1 << s;
    if (hrs < mul_lat)      return mul_lat - hrs - 1;
    else if (hrs > mul_lat) return hrs - mul_lat - 1;
    else                    return 0;
  endfunction

  function automatic int fifo2_wrap(input int depth);
    return (depth <= 1) ? 0 : depth - 1;
  endfunction

endpackage

// File: rtl/mod_cnt.sv
// Wrapping address counter: advances on en, wraps after the run-time wrap value, sync clear.
module mod_cnt
  import ntt_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = MAX_FIFO_ADDR_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] wrap,
  output logic [W-1:0] cnt
);

  logic w_last;

  // DEPTH bounds the count even if the selected wrap value is larger.
  assign w_last = (cnt >= wrap) || (cnt >= W'(DEPTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= w_last ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/ntt_seq.sv
// Sequencer for the NTT/INTT pipeline: streams RAM into the pipeline, writes results back,
// and drives the per-stage reorder-FIFO and shared mul-delay-FIFO addresses.
module ntt_seq
  import ntt_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int STAGES  = NTT_STAGE_CNT,
  parameter int MUL_LAT = MUL_STAGE_CNT,
  parameter int TIMEOUT = 1024
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic                                         mode,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         err,
  output logic                                         mem_re,
  output logic [2*$clog2(N)-1:0]                       mem_raddr,
  input  logic [2*DATA_WIDTH-1:0]                      mem_rdata,
  output logic                                         pipe_in_en,
  output logic [2*DATA_WIDTH-1:0]                      pipe_in,
  input  logic                                         pipe_out_en,
  input  logic [2*DATA_WIDTH-1:0]                      pipe_out,
  input  logic [STAGES-1:0]                            fifo_en,
  output logic [STAGES-1:0][MAX_FIFO_ADDR_BITS-1:0]    fifo2_addr,
  output logic [MAX_FIFO_ADDR_BITS-1:0]                fifom_addr,
  output logic                                         mem_we,
  output logic [2*$clog2(N)-1:0]                       mem_waddr,
  output logic [2*DATA_WIDTH-1:0]                      mem_wdata
);

  localparam int LN   = $clog2(N);
  localparam int HW   = LN - 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int FA_W = MAX_FIFO_ADDR_BITS;
  localparam logic [HW-1:0] LAST_BEAT = HW'(N / 2 - 1);

  state_t          r_state;
  logic            r_mode, r_busy, r_done, r_err;
  logic            r_mem_re, r_pipe_in_en, r_seen_out;
  logic [HW-1:0]   r_k, r_w;
  logic [TO_W-1:0] r_to_cnt;

  logic w_accept, w_active, w_any_en;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_active = (r_state == S_FEED) || (r_state == S_DRAIN);
  assign w_any_en = |fifo_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_mem_re     <= 1'b0;
      r_pipe_in_en <= 1'b0;
      r_seen_out   <= 1'b0;
      r_k          <= '0;
      r_w          <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_pipe_in_en <= r_mem_re;
      case (r_state)
        S_IDLE: if (start) begin
          r_state    <= S_FEED;
          r_mode     <= mode;
          r_err      <= 1'b0;
          r_busy     <= 1'b1;
          r_mem_re   <= 1'b1;
          r_seen_out <= 1'b0;
          r_k        <= '0;
          r_w        <= '0;
          r_to_cnt   <= '0;
        end
        S_FEED: begin
          if (pipe_out_en) begin
            r_w        <= r_w + HW'(1);
            r_seen_out <= 1'b1;
          end
          if (r_k == LAST_BEAT) begin
            r_state  <= S_DRAIN;
            r_mem_re <= 1'b0;
            r_to_cnt <= TO_W'(1);
          end else begin
            r_k <= r_k + HW'(1);
          end
        end
        S_DRAIN: begin
          if (pipe_out_en) begin
            r_w        <= r_w + HW'(1);
            r_seen_out <= 1'b1;
            if (r_w == LAST_BEAT) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else if (!r_seen_out) begin
            // r_to_cnt holds the number of cycles elapsed since the last feed beat.
            if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign mem_re     = r_mem_re;
  assign pipe_in_en = r_pipe_in_en;
  assign pipe_in    = mem_rdata;
  // N/2 is a power of two, so k + N/2 is k with the top address bit set.
  assign mem_raddr  = r_mem_re ? {1'b0, r_k, 1'b1, r_k} : '0;
  assign mem_we     = pipe_out_en && w_active;
  assign mem_waddr  = {1'b0, r_w, 1'b1, r_w};
  assign mem_wdata  = pipe_out;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int D_NTT  = fifo2_depth(gi, 1'b0, STAGES, MUL_LAT);
    localparam int D_INTT = fifo2_depth(gi, 1'b1, STAGES, MUL_LAT);
    localparam int D_MAX  = (D_NTT > D_INTT) ? D_NTT : D_INTT;

    logic [FA_W-1:0] w_wrap;
    assign w_wrap = r_mode ? FA_W'(fifo2_wrap(D_INTT)) : FA_W'(fifo2_wrap(D_NTT));

    mod_cnt #(.DEPTH((D_MAX < 1) ? 1 : D_MAX), .W(FA_W)) u_fifo2_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (fifo_en[gi]),
      .clr  (w_accept),
      .wrap (w_wrap),
      .cnt  (fifo2_addr[gi])
    );
  end

  mod_cnt #(.DEPTH(MUL_LAT - 1), .W(FA_W)) u_fifom_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (w_any_en),
    .clr  (w_accept),
    .wrap (FA_W'(MUL_LAT - 2)),
    .cnt  (fifom_addr)
  );

endmodule

// File: doc/ntt_seq.md
# ntt_seq

Sequencer and FIFO-address generator for the dual-path pipelined NTT/INTT datapath.
- Takes one start request and streams one polynomial from the coefficient RAM into the pipeline, two coefficients per cycle.
- Generates the per-stage reorder-FIFO and shared mul-delay-FIFO addresses the pipeline consumes.
- Writes the pipeline output back to the coefficient RAM, then signals done.
- Sits between the polynomial RAM / top-level control and the `ntt`/`intt` pipeline instances.

## Interface
Parameters:
- N, 256: polynomial length; power of two; N/2 beats per transform.
- STAGES, `NTT_STAGE_CNT`: butterfly stages, log2(N).
- MUL_LAT, `MUL_STAGE_CNT`: modular-multiplier latency in cycles.
- TIMEOUT, 1024: maximum cycles from the last feed beat to the first output beat before an error is flagged.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: reset, synchronous, active-low.
- start, in, 1: request a transform; sampled only in IDLE.
- mode, in, 1: 0 = NTT, 1 = INTT; latched at start; selects the FIFO depth table.
- busy, out, 1: high from the cycle after an accepted start through the DONE cycle.
- done, out, 1: one-cycle pulse on completion.
- err, out, 1: sticky timeout flag; cleared by the next accepted start.
- mem_re, out, 1: RAM read strobe.
- mem_raddr, out, 2 x log2(N): read addresses.
- mem_rdata, in, 2 x `DATA_WIDTH`: RAM read data, valid one cycle after mem_re.
- pipe_in_en, out, 1: pipeline in_en.
- pipe_in, out, 2 x `DATA_WIDTH`: pipeline input.
- pipe_out_en, in, 1: pipeline out_en.
- pipe_out, in, 2 x `DATA_WIDTH`: pipeline output.
- fifo_en, in, STAGES x 1: per-stage FIFO activity from the pipeline.
- fifo2_addr, out, STAGES x `MAX_FIFO_ADDR_BITS`: per-stage reorder-FIFO addresses.
- fifom_addr, out, `MAX_FIFO_ADDR_BITS`: shared mul-delay-FIFO address.
- mem_we, out, 1: RAM write strobe.
- mem_waddr, out, 2 x log2(N): write addresses.
- mem_wdata, out, 2 x `DATA_WIDTH`: write data.

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 latches mode, clears err and all counters, and goes to FEED.
  - start=0 holds IDLE.
  - start while not in IDLE is ignored.
- FEED, read side:
  - Read counter k runs 0..N/2-1, one per cycle.
  - mem_re=1, mem_raddr = {k, k+N/2}.
  - After k = N/2-1, go to DRAIN.
- FEED, pipeline side:
  - pipe_in_en is mem_re delayed by 1 cycle.
  - pipe_in = mem_rdata, combinational pass-through.
- DRAIN:
  - Write counter w increments on each pipe_out_en beat.
  - mem_we = pipe_out_en, mem_waddr = {w, w+N/2}, mem_wdata = pipe_out; all combinational.
  - After beat w = N/2-1, go to DONE.
  - Output beats that arrive while still in FEED are counted and written the same way.
- Timeout:
  - A timeout counter starts at the last feed beat and stops at the first pipe_out_en.
  - Reaching TIMEOUT sets err and goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- fifo2_addr[i]:
  - Mod-D(i) counter that increments only while fifo_en[i]=1 and holds otherwise.
  - Wraps from D(i)-1 to 0.
  - Reset to 0 on accepted start.
  - D(i) comes from the depth function for the latched mode; if D(i) ≤ 1 the address is constant 0.
- Depth function, with HRS = 2^s and s the stage index in pipeline order:
  - INTT: stage i has s = i.
  - NTT: stage i has s = STAGES-1-i.
  - D = MUL_LAT-HRS-1 if HRS < MUL_LAT.
  - D = HRS-MUL_LAT-1 if HRS > MUL_LAT.
  - D = 0 if HRS = MUL_LAT.
- fifom_addr:
  - Mod-(MUL_LAT-1) counter that increments while any fifo_en bit is 1.
  - Free-runs through the whole transform.

## Timing
- Reset (rst=0 at a clk edge): state=IDLE.
- Output values while in reset / after reset:
  - Strobes: busy, done, err, mem_re, pipe_in_en, mem_we = 0.
  - Addresses: all FIFO addresses = 0, mem_raddr = 0.
  - Data: pipe_in, mem_wdata, mem_waddr follow their combinational sources.
- Reset asserted mid-transform aborts immediately; no done pulse is produced.
- Start/read timing:
  - Start sampled at edge t → busy=1 and first mem_re at t+1.
  - pipe_in_en spans t+2 .. t+N/2+1.
- Done timing: done is asserted the cycle after the edge that samples the final write beat.
- busy drops together with done.
- No back-pressure: the pipeline always accepts input, and output is written in the cycle it appears.
- A FIFO counter wrap and its fifo_en deassertion in the same cycle: the wrap takes effect and the counter then holds at 0.

## Structure
- Shared package `ntt_pkg`:
  - Function `fifo2_depth(stage, mode)`.
  - State enum.
  - Width constants: log2(N) and `MAX_FIFO_ADDR_BITS` alias.
- One sub-module `mod_cnt`, parameterised by DEPTH: enable, sync clear, wrapping output.
  - Instantiated STAGES+1 times from a generate loop.
  - The per-stage counter depth is chosen by mode via a mux on the wrap value.
- The FSM and the read/write counters stay in `ntt_seq`.

## Test plan
- Basic INTT, N=256, MUL_LAT=6:
  - Stimulus: start with mode=1.
  - Required: 128 consecutive mem_re beats with mem_raddr {0,128}..{127,255}; pipe_in_en high for exactly 128 cycles starting 2 cycles after start.
- Write-back with a behavioural pipeline model:
  - Required: 128 writes with mem_waddr {w, w+128}; done is one pulse; busy falls with done; err=0.
- FIFO wrap:
  - Stimulus: hold fifo_en[3]=1 for 20 cycles (INTT, HRS=8, D=1), and fifo_en[0] for 20 cycles (D=4).
  - Required: fifo2_addr[3] stays 0; fifo2_addr[0] sequence 0,1,2,3,0,…; fifom_addr wraps at 5.
- Start during a transform:
  - Stimulus: pulse start at cycle 50 of FEED.
  - Required: no restart, and the read sequence continues unbroken.
- Timeout:
  - Stimulus: pipe_out_en never asserts.
  - Required: err=1 and a done pulse TIMEOUT cycles after the last feed beat; err clears on the next start.
- Reset mid-DRAIN:
  - Stimulus: rst=0 for 1 cycle.
  - Required: next cycle all strobes 0, all addresses 0, no done pulse; a new start then runs the full sequence normally.
